clock_period_meter: RTL and testbench



---
 rtl/clock_period_meter.sv | 116 +++++++++++
 tb/tb_clock_period_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Clock period meter: measures the period and high time of a slow,
// asynchronous square wave in system clock cycles. One result per complete
// input period, announced with a single-cycle valid pulse. A stuck or
// too-slow input saturates the period counter, raises a sticky timeout and
// re-arms the meter on the next rising edge.
module clock_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LAST_INC = {{(WIDTH-1){1'b1}}, 1'b0};

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  state_t           r_state;
  logic [WIDTH-1:0] r_cntP;
  logic [WIDTH-1:0] r_cntH;

  logic w_rise;
  logic w_fall;
  logic w_nearSat;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  // The next increment would land the period counter on its all-ones value.
  assign w_nearSat = (r_cntP == LAST_INC);

  // Two-flop synchronizer plus history flop; resetting high means an input
  // that is already high when reset releases does not look like a rise.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Measurement FSM: counts cycles from rise to rise, latches the result on
  // the closing rise and starts the next period in the same cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cntP    <= '0;
      r_cntH    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_cntP  <= ONE;
            r_cntH  <= ONE;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_nearSat) begin
            r_cntP  <= r_cntP + ONE;
            timeout <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cntP <= r_cntP + ONE;
            if (w_fall) begin
              r_state <= LOW;
            end else begin
              r_cntH <= r_cntH + ONE;
            end
          end
        end
        LOW: begin
          if (w_rise) begin
            period    <= r_cntP;
            high_time <= r_cntH;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            r_cntP    <= ONE;
            r_cntH    <= ONE;
            r_state   <= HIGH;
          end else if (w_nearSat) begin
            r_cntP  <= r_cntP + ONE;
            timeout <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cntP <= r_cntP + ONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a 16-bit meter for the nominal, extreme,
// latency and reset scenarios and an 8-bit meter for counter saturation.
// Expected results are queued when a period is driven and compared when
// the meter raises valid.
`timescale 1ns/1ps
module tb_clock_period_meter;

  logic        clk;
  logic        rst16;
  logic        rst8;
  logic        sig16;
  logic        sig8;
  logic [15:0] period16;
  logic [15:0] high16;
  logic        valid16;
  logic        timeout16;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        timeout8;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] q16[$];
  logic [31:0] q8[$];
  logic        prevValid16 = 1'b0;
  logic        prevValid8  = 1'b0;

  clock_period_meter #(.WIDTH(16)) dut16 (
    .clk_in   (clk),
    .reset    (rst16),
    .sig_in   (sig16),
    .period   (period16),
    .high_time(high16),
    .valid    (valid16),
    .timeout  (timeout16)
  );

  clock_period_meter #(.WIDTH(8)) dut8 (
    .clk_in   (clk),
    .reset    (rst8),
    .sig_in   (sig8),
    .period   (period8),
    .high_time(high8),
    .valid    (valid8),
    .timeout  (timeout8)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Hold one meter's input at a level for n clock edges; always returns 1 ns
  // after a rising edge so the next drive is captured by the following edge.
  task automatic holdSig(input bit sel8, input logic v, input int n);
    if (sel8) sig8 = v;
    else sig16 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one period of h high and l low cycles; when push is set, the
  // result is expected once the next rise closes this period.
  task automatic applyStimulus(input bit sel8, input int h, input int l,
                               input bit push);
    logic [15:0] hp;
    logic [15:0] hh;
    hp = 16'(h + l);
    hh = 16'(h);
    if (push) begin
      if (sel8) q8.push_back({hp, hh});
      else q16.push_back({hp, hh});
    end
    holdSig(sel8, 1'b1, h);
    holdSig(sel8, 1'b0, l);
  endtask

  // Scoreboard for the 16-bit meter, sampled on the falling edge.
  always @(negedge clk) begin : mon16
    logic [31:0] e;
    if (valid16) begin
      checkOutput("validWidth16", {31'd0, prevValid16}, 32'd0);
      if (q16.size() == 0) begin
        checkOutput("unexpectedValid16", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        checkOutput("period16", {16'd0, period16}, {16'd0, e[31:16]});
        checkOutput("high16", {16'd0, high16}, {16'd0, e[15:0]});
        checkOutput("timeoutOnValid16", {31'd0, timeout16}, 32'd0);
      end
    end
    prevValid16 = valid16;
  end

  // Scoreboard for the 8-bit meter, sampled on the falling edge.
  always @(negedge clk) begin : mon8
    logic [31:0] e;
    if (valid8) begin
      checkOutput("validWidth8", {31'd0, prevValid8}, 32'd0);
      if (q8.size() == 0) begin
        checkOutput("unexpectedValid8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("period8", {24'd0, period8}, {24'd0, e[23:16]});
        checkOutput("high8", {24'd0, high8}, {24'd0, e[7:0]});
        checkOutput("timeoutOnValid8", {31'd0, timeout8}, 32'd0);
      end
    end
    prevValid8 = valid8;
  end

  // Main sequence.
  initial begin
    rst16 = 1'b0;
    rst8  = 1'b0;
    sig16 = 1'b1;
    sig8  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstPeriod16", {16'd0, period16}, 32'd0);
    checkOutput("rstHigh16", {16'd0, high16}, 32'd0);
    checkOutput("rstValid16", {31'd0, valid16}, 32'd0);
    checkOutput("rstTimeout16", {31'd0, timeout16}, 32'd0);
    checkOutput("rstPeriod8", {24'd0, period8}, 32'd0);
    checkOutput("rstTimeout8", {31'd0, timeout8}, 32'd0);
    rst16 = 1'b1;
    rst8  = 1'b1;

    // Input already high at reset release: no rise, nothing measured.
    holdSig(1'b0, 1'b1, 100);
    checkOutput("idlePeriod16", {16'd0, period16}, 32'd0);
    checkOutput("idleHigh16", {16'd0, high16}, 32'd0);
    checkOutput("idleTimeout16", {31'd0, timeout16}, 32'd0);

    // Nominal 513/511; the first rise only arms the meter.
    holdSig(1'b0, 1'b0, 20);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 513, 511, 1'b1);

    // Minimum pulses, then 3 high / 1 low.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1, 1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3, 1, 1'b1);
    applyStimulus(1'b0, 5, 5, 1'b1);

    // Latency: rise captured at edge k, valid visible after edge k+2.
    q16.push_back({16'd30, 16'd20});
    sig16 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("latencyK0", {31'd0, valid16}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latencyK1", {31'd0, valid16}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latencyK2", {31'd0, valid16}, 32'd1);
    holdSig(1'b0, 1'b1, 17);
    holdSig(1'b0, 1'b0, 10);

    // Reset 30 cycles into a high phase of a 50/50 input.
    holdSig(1'b0, 1'b1, 30);
    checkOutput("preResetPeriod16", {16'd0, period16}, 32'd30);
    rst16 = 1'b0;
    #1;
    checkOutput("midRstPeriod16", {16'd0, period16}, 32'd0);
    checkOutput("midRstHigh16", {16'd0, high16}, 32'd0);
    checkOutput("midRstValid16", {31'd0, valid16}, 32'd0);
    checkOutput("midRstTimeout16", {31'd0, timeout16}, 32'd0);
    @(posedge clk);
    #1;
    rst16 = 1'b1;
    holdSig(1'b0, 1'b1, 19);
    holdSig(1'b0, 1'b0, 50);
    applyStimulus(1'b0, 50, 50, 1'b1);
    holdSig(1'b0, 1'b1, 5);
    holdSig(1'b0, 1'b0, 5);
    checkOutput("endTimeout16", {31'd0, timeout16}, 32'd0);

    // Saturation on the 8-bit meter.
    holdSig(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 10, 10, 1'b1);
    holdSig(1'b1, 1'b1, 10);
    holdSig(1'b1, 1'b0, 200);
    checkOutput("preSatTimeout8", {31'd0, timeout8}, 32'd0);
    holdSig(1'b1, 1'b0, 100);
    checkOutput("satTimeout8", {31'd0, timeout8}, 32'd1);
    checkOutput("satPeriod8", {24'd0, period8}, 32'd20);
    checkOutput("satHigh8", {24'd0, high8}, 32'd10);
    applyStimulus(1'b1, 10, 10, 1'b1);
    checkOutput("armedTimeout8", {31'd0, timeout8}, 32'd1);
    applyStimulus(1'b1, 7, 5, 1'b1);
    holdSig(1'b1, 1'b1, 5);
    holdSig(1'b1, 1'b0, 5);
    checkOutput("resumeTimeout8", {31'd0, timeout8}, 32'd0);
    checkOutput("resumePeriod8", {24'd0, period8}, 32'd12);

    checkOutput("pending16", q16.size(), 32'd0);
    checkOutput("pending8", q8.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
